// File: rtl/vc_pop_scheduler_if.sv
// Bus between the pop scheduler, the main FIFO and the two VC FIFOs.
// master is the scheduler side, slave is the FIFO side.
interface vc_pop_scheduler_if #(
  parameter int DATA_SIZE = 6
);
  logic                 fifo_empty_main;
  logic                 fifo_error_main;
  logic [DATA_SIZE-1:0] data_main;
  logic                 pop_main;
  logic                 pause_vc0;
  logic                 pause_vc1;
  logic                 error_vc0;
  logic                 error_vc1;
  logic                 push_vc0;
  logic                 push_vc1;
  logic [DATA_SIZE-1:0] data_vc;

  modport master (
    input  fifo_empty_main, fifo_error_main, data_main,
    input  pause_vc0, pause_vc1, error_vc0, error_vc1,
    output pop_main, push_vc0, push_vc1, data_vc
  );

  modport slave (
    output fifo_empty_main, fifo_error_main, data_main,
    output pause_vc0, pause_vc1, error_vc0, error_vc1,
    input  pop_main, push_vc0, push_vc1, data_vc
  );
endinterface

// File: rtl/vc_pop_scheduler.sv
// Pops the main FIFO and steers each word to VC0/VC1 by its selector bit;
// also owns the FIFO threshold registers and the RESET/INIT/IDLE/ACTIVE/ERROR FSM.
module vc_pop_scheduler #(
  parameter int DATA_SIZE  = 6,
  parameter int VC_SEL_BIT = 4,
  parameter int THRESH_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [THRESH_W-1:0] afMF_in,
  input  logic [THRESH_W-1:0] aeMF_in,
  input  logic [THRESH_W-1:0] afVC_in,
  input  logic [THRESH_W-1:0] aeVC_in,
  vc_pop_scheduler_if.master  bus,
  output logic [THRESH_W-1:0] afMF_o,
  output logic [THRESH_W-1:0] aeMF_o,
  output logic [THRESH_W-1:0] afVC_o,
  output logic [THRESH_W-1:0] aeVC_o,
  output logic [2:0]          state,
  output logic                idle_out,
  output logic                error_out
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  logic [2:0] state_next;
  logic       any_error;
  logic       in_flight;
  logic       pop;

  assign any_error = bus.fifo_error_main | bus.error_vc0 | bus.error_vc1;

  // Both pauses gate the pop: the destination VC is only known once the word arrives.
  assign pop = (state == ST_ACTIVE) && !bus.fifo_empty_main &&
               !bus.pause_vc0 && !bus.pause_vc1 && !any_error;
  assign bus.pop_main = pop;

  assign idle_out  = (state == ST_IDLE);
  assign error_out = (state == ST_ERROR);

  always_comb begin
    // NOTE: state_next defaults to state so every path assigns it and no latch is inferred.
    state_next = state;
    case (state)
      ST_RESET: state_next = ST_INIT;
      ST_INIT: begin
        if (any_error)  state_next = ST_ERROR;
        else if (!init) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_error)                 state_next = ST_ERROR;
        else if (init)                 state_next = ST_INIT;
        else if (!bus.fifo_empty_main) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // init is deliberately ignored here; leave only once fully drained.
        if (any_error)                                       state_next = ST_ERROR;
        else if (bus.fifo_empty_main && !pop && !in_flight)  state_next = ST_IDLE;
      end
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_ERROR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RESET;
    else       state <= state_next;
  end

  // Thresholds track the inputs throughout INIT and hold everywhere else, including ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      afMF_o <= '0;
      aeMF_o <= '0;
      afVC_o <= '0;
      aeVC_o <= '0;
    end else if (state == ST_INIT) begin
      afMF_o <= afMF_in;
      aeMF_o <= aeMF_in;
      afVC_o <= afVC_in;
      aeVC_o <= aeVC_in;
    end
  end

  // Two-edge pipeline: pop -> in_flight (data_main valid) -> registered push.
  // A word in flight is pushed regardless of state, so it survives entry to ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight    <= 1'b0;
      bus.push_vc0 <= 1'b0;
      bus.push_vc1 <= 1'b0;
      bus.data_vc  <= '0;
    end else begin
      in_flight    <= pop;
      bus.push_vc0 <= in_flight && !bus.data_main[VC_SEL_BIT];
      bus.push_vc1 <= in_flight &&  bus.data_main[VC_SEL_BIT];
      if (in_flight) bus.data_vc <= bus.data_main;
    end
  end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Randomized bench for vc_pop_scheduler: a queue-backed main-FIFO stub plus a
// transaction-level reference model of the expected pops, pushes and modes.
module tb_vc_pop_scheduler;
  localparam int DATA_SIZE  = 6;
  localparam int VC_SEL_BIT = 4;
  localparam int THRESH_W   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                init;
  logic [THRESH_W-1:0] afMF_in, aeMF_in, afVC_in, aeVC_in;
  logic [THRESH_W-1:0] afMF_o, aeMF_o, afVC_o, aeVC_o;
  logic [2:0]          state;
  logic                idle_out, error_out;

  vc_pop_scheduler_if #(.DATA_SIZE(DATA_SIZE)) bus ();

  vc_pop_scheduler #(
    .DATA_SIZE (DATA_SIZE),
    .VC_SEL_BIT(VC_SEL_BIT),
    .THRESH_W  (THRESH_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .afMF_in  (afMF_in),
    .aeMF_in  (aeMF_in),
    .afVC_in  (afVC_in),
    .aeVC_in  (aeVC_in),
    .bus      (bus),
    .afMF_o   (afMF_o),
    .aeMF_o   (aeMF_o),
    .afVC_o   (afVC_o),
    .aeVC_o   (aeVC_o),
    .state    (state),
    .idle_out (idle_out),
    .error_out(error_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Main FIFO contents as seen by the stub (driven by the DUT's pops) and by the model.
  logic [DATA_SIZE-1:0] stub_q[$];
  logic [DATA_SIZE-1:0] ref_q[$];

  // Reference model: mode 0..4 = RESET, INIT, IDLE, ACTIVE, ERROR.
  int                   m_mode;
  bit                   m_infl;
  logic [DATA_SIZE-1:0] m_word;
  bit                   e_p0, e_p1;
  logic [DATA_SIZE-1:0] e_data;
  logic [7:0]           e_thr;

  task automatic feed(input logic [DATA_SIZE-1:0] w);
    stub_q.push_back(w);
    ref_q.push_back(w);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_infl = 1'b0;
    e_p0   = 1'b0;
    e_p1   = 1'b0;
    e_data = '0;
    e_thr  = '0;
  endtask

  // One clock: drive inputs at negedge, check, advance the model, then let the stub
  // present the popped word just after the edge.
  task automatic do_cycle(input bit i_init, input bit p0, input bit p1,
                          input bit em, input bit e0, input bit e1);
    bit got_pop, e_pop, err, empty, old_infl;
    @(negedge clk);
    init                = i_init;
    bus.pause_vc0       = p0;
    bus.pause_vc1       = p1;
    bus.fifo_error_main = em;
    bus.error_vc0       = e0;
    bus.error_vc1       = e1;
    bus.fifo_empty_main = (stub_q.size() == 0);
    #1;
    err   = em | e0 | e1;
    empty = (ref_q.size() == 0);
    e_pop = (m_mode == 3) && !empty && !p0 && !p1 && !err;
    check("pop_main",  bus.pop_main, e_pop);
    check("state",     state, m_mode);
    check("push_vc0",  bus.push_vc0, e_p0);
    check("push_vc1",  bus.push_vc1, e_p1);
    check("data_vc",   bus.data_vc, e_data);
    check("idle_out",  idle_out, m_mode == 2);
    check("error_out", error_out, m_mode == 4);
    check("thresholds", {afMF_o, aeMF_o, afVC_o, aeVC_o}, e_thr);
    got_pop = bus.pop_main;

    // Words leave the main FIFO in order and are pushed two edges after their pop.
    if (m_infl) begin
      e_data = m_word;
      e_p1   = m_word[VC_SEL_BIT];
      e_p0   = !m_word[VC_SEL_BIT];
    end else begin
      e_p0 = 1'b0;
      e_p1 = 1'b0;
    end
    old_infl = m_infl;
    m_infl   = e_pop;
    if (e_pop) m_word = ref_q.pop_front();
    if (m_mode == 1) e_thr = {afMF_in, aeMF_in, afVC_in, aeVC_in};
    if (m_mode == 0)                 m_mode = 1;
    else if (m_mode == 4)            m_mode = 4;
    else if (err)                    m_mode = 4;
    else if (m_mode == 1)            m_mode = i_init ? 1 : 2;
    else if (m_mode == 2)            m_mode = i_init ? 1 : (empty ? 2 : 3);
    else if (empty && !e_pop && !old_infl) m_mode = 2;

    @(posedge clk);
    #1;
    if (got_pop) begin
      if (stub_q.size() != 0) bus.data_main = stub_q.pop_front();
      else check("pop_on_empty", 1'b1, 1'b0);
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_state",  state, 3'd0);
    check("rst_pop",    bus.pop_main, 1'b0);
    check("rst_push",   {bus.push_vc0, bus.push_vc1}, 2'b00);
    check("rst_data",   bus.data_vc, '0);
    check("rst_thr",    {afMF_o, aeMF_o, afVC_o, aeVC_o}, 8'h00);
    check("rst_error",  error_out, 1'b0);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    init  = 1'b0;
    {afMF_in, aeMF_in, afVC_in, aeVC_in} = '0;
    bus.fifo_empty_main = 1'b1;
    bus.fifo_error_main = 1'b0;
    bus.data_main       = '0;
    bus.pause_vc0       = 1'b0;
    bus.pause_vc1       = 1'b0;
    bus.error_vc0       = 1'b0;
    bus.error_vc1       = 1'b0;
    model_reset();

    // Config load: 3/1/2/1 latched in INIT, held after init drops.
    apply_reset(2);
    afMF_in = 2'd3; aeMF_in = 2'd1; afVC_in = 2'd2; aeVC_in = 2'd1;
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    {afMF_in, aeMF_in, afVC_in, aeVC_in} = '0;
    idle_cycles(2);
    check("cfg_loaded", {afMF_o, aeMF_o, afVC_o, aeVC_o}, 8'b11_01_10_01);
    check("cfg_idle", state, 3'd2);

    // Routing: 0x15 to VC1, then 0x05 to VC0, back to IDLE.
    feed(6'h15);
    feed(6'h05);
    idle_cycles(7);

    // Back-pressure on VC0 for 3 cycles with the main FIFO non-empty.
    feed(6'h21); feed(6'h12); feed(6'h3F);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(6);

    // Pause on VC1 rising while 0x10 is in flight.
    feed(6'h10); feed(6'h11);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);

    // Randomized traffic: random pauses, feeds, init pulses and thresholds.
    for (int i = 0; i < 400; i++) begin
      {afMF_in, aeMF_in, afVC_in, aeVC_in} = 8'($urandom);
      if ($urandom_range(0, 1) == 1) feed(6'($urandom));
      do_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, 1'b0, 1'b0, 1'b0);
    end
    idle_cycles(4);
    while (ref_q.size() != 0 && n_checks < 20000) idle_cycles(1);
    idle_cycles(4);

    // Error while a word is in flight: the push completes, ERROR is sticky.
    feed(6'h1A); feed(6'h07);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      {afMF_in, aeMF_in, afVC_in, aeVC_in} = 8'($urandom);
      do_cycle(i[0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("err_sticky", error_out, 1'b1);

    // Recover through reset, drain the leftover word, then reset mid-transfer.
    apply_reset(2);
    idle_cycles(8);
    feed(6'h2B);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset(1);
    idle_cycles(5);

    // Errors on each VC input from IDLE.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cycles(2);
    apply_reset(1);
    idle_cycles(3);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vc_pop_scheduler.md
Name: vc_pop_scheduler

Overview:
- Controller that sequences the main FIFO and routes its words to the two virtual-channel (VC) FIFOs.
- Holds the threshold configuration registers (main and VC almost-full/almost-empty) and drives them into the FIFOs.
- Decides each cycle whether to pop the main FIFO, then steers the popped word to VC0 or VC1 by a selector bit.
- Runs a RESET/INIT/IDLE/ACTIVE/ERROR state machine that gates all traffic; sits between the main FIFO and the VC FIFOs.

Parameters:
DATA_SIZE, 6, width of a data word.
VC_SEL_BIT, 4, bit index of the word that selects the VC (0 selects VC0, 1 selects VC1).
THRESH_W, 2, width of every threshold field.

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
init  input  1  request to (re)load thresholds.
afMF_in  input  THRESH_W  main almost-full threshold to load.
aeMF_in  input  THRESH_W  main almost-empty threshold to load.
afVC_in  input  THRESH_W  VC almost-full threshold to load.
aeVC_in  input  THRESH_W  VC almost-empty threshold to load.
fifo_empty_main  input  1  main FIFO empty.
fifo_error_main  input  1  main FIFO over/underflow.
data_main  input  DATA_SIZE  main FIFO read data; valid the cycle after pop_main.
pause_vc0  input  1  VC0 almost-full.
pause_vc1  input  1  VC1 almost-full.
error_vc0  input  1  VC0 FIFO error.
error_vc1  input  1  VC1 FIFO error.
afMF_o  output  THRESH_W  latched main almost-full threshold.
aeMF_o  output  THRESH_W  latched main almost-empty threshold.
afVC_o  output  THRESH_W  latched VC almost-full threshold.
aeVC_o  output  THRESH_W  latched VC almost-empty threshold.
pop_main  output  1  pop request to the main FIFO (combinational).
push_vc0  output  1  push to VC0 (registered).
push_vc1  output  1  push to VC1 (registered).
data_vc  output  DATA_SIZE  word for the VC FIFOs (registered).
state  output  3  encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
idle_out  output  1  high when state is IDLE.
error_out  output  1  high when state is ERROR.

Behaviour:
- Reset behaviour: while reset is high, state=RESET; all threshold outputs, push_vc0/1, data_vc, the in-flight flag and error_out are 0; pop_main is 0.
- RESET -> INIT on the first clock edge after reset deasserts.
- INIT:
  - Every cycle, latch afMF_in, aeMF_in, afVC_in and aeVC_in into the output registers.
  - Stay in INIT while init=1; go to IDLE when init=0. The last latched values are kept.
- IDLE:
  - If init=1, go to INIT; init has priority.
  - Else if fifo_empty_main=0, go to ACTIVE.
- ACTIVE:
  - pop_main = !fifo_empty_main && !pause_vc0 && !pause_vc1 && !any_error.
  - Both pauses gate the pop because the destination VC is unknown until the data arrives. Pause is almost-full, so the one word already in flight always fits.
  - init is ignored in ACTIVE.
  - Go to IDLE when fifo_empty_main=1, pop_main=0 and no word is in flight.
- In-flight pipeline:
  - Any cycle with pop_main=1 sets the in-flight flag for exactly the next cycle.
  - In that next cycle the block samples data_main. At the following edge it registers data_vc=data_main and pulses push_vc0 or push_vc1 for one cycle, selected by data_main[VC_SEL_BIT].
  - Latency from pop_main to the push pulse is 2 edges.
  - Back-to-back pops give a push every cycle (throughput 1 word/clk).
- ERROR:
  - any_error = fifo_error_main | error_vc0 | error_vc1.
  - If any_error is sampled high in INIT, IDLE or ACTIVE, the next state is ERROR.
  - ERROR is sticky until reset; error_out=1 and pop_main=0.
  - A word already in flight when ERROR is entered is still pushed, since it has already left the main FIFO.
  - Threshold registers hold their values.
- Reset asserted mid-transfer: everything clears immediately and the in-flight word is discarded.
- Simultaneous pause and a pending pop in the same cycle: no pop. A pause that rises during the in-flight cycle does not cancel that push.

Test Plan:
- Config load: reset 2 cycles, init=1 with afMF_in=3, aeMF_in=1, afVC_in=2, aeVC_in=1, then init=0 -> state 0 -> 1 -> 2; outputs read 3/1/2/1 and hold after init drops.
- Routing: main holds 0x15 then 0x05 (bit4 = 1, then 0); no pauses -> pop_main high 2 cycles; push_vc1 with data_vc=0x15, then push_vc0 with data_vc=0x05, each 2 edges after its pop; afterwards state returns to IDLE.
- Back-pressure: pause_vc0=1 for 3 cycles while main is non-empty -> pop_main=0 for those cycles; pops resume on the cycle pause drops; no word is lost or duplicated.
- Pause during flight: pop 0x10, then raise pause_vc1 the next cycle -> push_vc1 with 0x10 still occurs; no further pop until pause clears.
- Error: fifo_error_main pulsed 1 cycle in ACTIVE with a word in flight -> in-flight push completes; state=4 and error_out=1 persist; pop_main stays 0; only reset returns the block to RESET.
- Reset mid-operation: assert reset the cycle after a pop -> no push occurs; all outputs read 0 asynchronously.
